// File: rtl/ucode_sequencer.sv
// ucode_sequencer
//   Microcode T-state sequencer. It fetches an instruction word from the bus at T=1.
//   It then steps through T-states until the microcode ROM returns an all-zero word,
//   or until T=7, at which point the instruction retires.
//   A halt request is only taken at an instruction boundary.
//
// Optional feature macro: INSTR_COUNT_EN
//   When defined, the block adds a 16-bit retired-instruction counter and its port.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   stall      in   memory/bus not ready; freezes sequencing (RUN only)
//   halt       in   halt request, taken at end of instruction
//   bus[15:0]  in   instruction word, latched at T=1
//   uinstr     in   microinstruction from ROM for (instr, T)
//   T[2:0]     out  current T-state
//   instr      out  instruction register
//   running    out  1 in RUN, 0 in HALTED
//   instr_done out  one-cycle pulse after each retired instruction
//   retired    out  retired count (INSTR_COUNT_EN only)
module ucode_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt,
    input  logic [15:0] bus,
    input  logic [15:0] uinstr,
    output logic [2:0]  T,
    output logic [15:0] instr,
    output logic        running,
    output logic        instr_done
`ifdef INSTR_COUNT_EN
    ,
    output logic [15:0] retired
`endif
);

    typedef enum logic {RUN = 1'b1, HALTED = 1'b0} state_t;

    state_t      state, state_n;
    logic [2:0]  t_n;
    logic [15:0] instr_n;
    logic        done_n;
    logic        end_instr;
`ifdef INSTR_COUNT_EN
    logic [15:0] retired_n;
`endif

    // The RUN encoding is 1, so running is the state flop itself.
    assign running = (state == RUN);

    // The fetch at T=0/1 always completes, so the zero-word end test only applies from T=2.
    assign end_instr = (state == RUN) && !stall && (T >= 3'd2) &&
                       ((uinstr == 16'h0000) || (T == 3'd7));

    always_comb begin
        state_n = state;
        t_n     = T;
        instr_n = instr;
        done_n  = 1'b0;
`ifdef INSTR_COUNT_EN
        retired_n = retired;
`endif
        if (state == HALTED) begin
            // In HALTED, stall is ignored.
            t_n = 3'd0;
            if (!halt) state_n = RUN;
        end else if (stall) begin
            // Everything holds while stalled.
        end else if (end_instr) begin
            t_n     = 3'd0;
            done_n  = 1'b1;
            state_n = halt ? HALTED : RUN;
`ifdef INSTR_COUNT_EN
            retired_n = retired + 16'd1;
`endif
        end else begin
            if (T == 3'd1) instr_n = bus;
            t_n = T + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            T          <= 3'd0;
            instr      <= 16'h0000;
            instr_done <= 1'b0;
`ifdef INSTR_COUNT_EN
            retired    <= 16'h0000;
`endif
        end else begin
            state      <= state_n;
            T          <= t_n;
            instr      <= instr_n;
            instr_done <= done_n;
`ifdef INSTR_COUNT_EN
            retired    <= retired_n;
`endif
        end
    end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer.
// The bench first runs directed scenarios and then randomized cycles.
// Both are checked against a behavioural model held in plain integers.
module tb_ucode_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0, stall = 1'b0, halt = 1'b0;
    logic [15:0] bus = 16'h0, uinstr = 16'h0;
    logic [2:0]  T;
    logic [15:0] instr;
    logic        running, instr_done;
`ifdef INSTR_COUNT_EN
    logic [15:0] retired;
`endif

    int checks = 0;
    int errors = 0;

    // reference model
    int m_t = 0, m_instr = 0, m_ret = 0;
    bit m_run = 1'b1, m_done = 1'b0;

    always #5 clk = ~clk;

    ucode_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt),
        .bus(bus), .uinstr(uinstr), .T(T), .instr(instr),
        .running(running), .instr_done(instr_done)
`ifdef INSTR_COUNT_EN
        , .retired(retired)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_model();
        check("T",          {13'd0, T},          16'(m_t));
        check("instr",      instr,               16'(m_instr));
        check("running",    {15'd0, running},    {15'd0, m_run});
        check("instr_done", {15'd0, instr_done}, {15'd0, m_done});
`ifdef INSTR_COUNT_EN
        check("retired",    retired,             16'(m_ret));
`endif
    endtask

    // Apply one cycle of inputs, advance the model by the rules, and compare after the edge.
    task automatic step(input bit r, input bit s, input bit h, input logic [15:0] b, input logic [15:0] u);
        reset = r; stall = s; halt = h; bus = b; uinstr = u;
        if (r) begin
            m_t = 0; m_instr = 0; m_run = 1; m_done = 0; m_ret = 0;
        end else if (!m_run) begin
            m_done = 0; m_t = 0;
            if (!h) m_run = 1;
        end else if (s) begin
            m_done = 0;
        end else if (m_t >= 2 && (u == 16'h0 || m_t == 7)) begin
            m_t = 0; m_done = 1; m_ret = (m_ret + 1) % 65536; m_run = !h;
        end else begin
            if (m_t == 1) m_instr = b;
            m_t = (m_t + 1) % 8;
            m_done = 0;
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        // reset, with stall and halt also high to show that reset overrides them
        step(1, 1, 1, 16'hFFFF, 16'h0);
        check("rst_T",       {13'd0, T}, 16'd0);
        check("rst_instr",   instr, 16'h0000);
        check("rst_running", {15'd0, running}, 16'd1);
        check("rst_done",    {15'd0, instr_done}, 16'd0);

        // short instruction: fetch 0300, end on a zero word at T=3
        step(0, 0, 0, 16'hAAAA, 16'h0);   // T0->1: zero word ignored during fetch
        step(0, 0, 0, 16'h0300, 16'h0);   // T1->2: latch bus, zero word ignored
        check("fetch_instr", instr, 16'h0300);
        step(0, 0, 0, 16'h1111, 16'h45C0);
        check("T3", {13'd0, T}, 16'd3);
        step(0, 0, 0, 16'h2222, 16'h0);
        check("end_T0",   {13'd0, T}, 16'd0);
        check("end_done", {15'd0, instr_done}, 16'd1);
        check("hold_instr", instr, 16'h0300);

        // long instruction: runs to T=7 and wraps to 0
        step(0, 0, 0, 16'h0, 16'h1234);
        check("done_clear", {15'd0, instr_done}, 16'd0);
        step(0, 0, 0, 16'h6400, 16'h1234);
        for (int i = 2; i < 7; i++) step(0, 0, 0, 16'h0, 16'h1234);
        check("T7", {13'd0, T}, 16'd7);
        step(0, 0, 0, 16'h0, 16'h1234);
        check("wrap_T0",   {13'd0, T}, 16'd0);
        check("wrap_done", {15'd0, instr_done}, 16'd1);

        // stall for 3 cycles at T=2
        step(0, 0, 0, 16'h0, 16'h1);
        step(0, 0, 0, 16'h5A5A, 16'h1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 16'hDEAD, 16'h0);
            check("stall_T", {13'd0, T}, 16'd2);
            check("stall_instr", instr, 16'h5A5A);
        end
        step(0, 0, 0, 16'h0, 16'h1);
        check("resume_T", {13'd0, T}, 16'd3);

        // halt raised at T=3, instruction ends at T=4
        step(0, 0, 1, 16'h0, 16'h1);
        check("halt_mid_T", {13'd0, T}, 16'd4);
        check("halt_mid_run", {15'd0, running}, 16'd1);
        step(0, 0, 1, 16'h0, 16'h0);
        check("halted_run", {15'd0, running}, 16'd0);
        step(0, 1, 1, 16'h0, 16'h0);       // stall has no effect while HALTED
        check("halted_T", {13'd0, T}, 16'd0);
        step(0, 0, 0, 16'h0, 16'h0);
        check("unhalt_run", {15'd0, running}, 16'd1);
        check("unhalt_T",   {13'd0, T}, 16'd0);
        step(0, 0, 0, 16'h0, 16'h0);
        check("unhalt_T1",  {13'd0, T}, 16'd1);

        // reset mid-instruction aborts it without a done pulse
        step(0, 0, 0, 16'h7777, 16'h1);
        step(1, 0, 0, 16'h0, 16'h0);
        check("abort_done",  {15'd0, instr_done}, 16'd0);
        check("abort_instr", instr, 16'h0000);

        // randomized cycles
        for (int i = 0; i < 600; i++) begin
            bit r, s, h;
            logic [15:0] u;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 20);
            h = m_run ? ($urandom_range(0, 99) < 10) : ($urandom_range(0, 1) == 1);
            u = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            step(r, s, h, 16'($urandom), u);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ucode_sequencer.md
UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the clk rising edge.
REQ-003 SHALL have port stall, input, 1 bit: memory/bus not ready; freezes sequencing while high.
REQ-004 SHALL have port halt, input, 1 bit: halt request, honoured only at an instruction boundary.
REQ-005 SHALL have port bus, input, 16 bits: data bus carrying the fetched instruction word.
REQ-006 SHALL have port uinstr, input, 16 bits: current microinstruction returned by the microcode ROM for (instr, T).
REQ-007 SHALL have port T, output, 3 bits: current T-state, driving the microcode ROM.
REQ-008 SHALL have port instr, output, 16 bits: instruction register, driving the microcode ROM.
REQ-009 SHALL have port running, output, 1 bit: high in state RUN, low in state HALTED.
REQ-010 SHALL have port instr_done, output, 1 bit: registered one-cycle pulse per retired instruction.
REQ-011 SHALL have port retired, output, 16 bits, present only with INSTR_COUNT_EN: retired-instruction count.

Function
REQ-012 SHALL implement two states, RUN and HALTED, with all outputs registered.
REQ-013 In RUN with stall=0, T SHALL advance T+1 per cycle, except as given by REQ-015 and REQ-016.
REQ-014 In RUN with stall=1, T, instr, state and retired SHALL hold, and instr_done SHALL be 0 next cycle.
REQ-015 At T=1 with stall=0, instr SHALL load bus, visible when T=2; instr SHALL not change at any other T.
REQ-016 End of instruction SHALL occur at T>=2, stall=0, and either uinstr==16'h0000 or T==7.
REQ-016a At end of instruction, next T SHALL be 0 (3-bit wrap, no T=8).
REQ-017 At T=0 and T=1, uinstr==0 SHALL NOT end the instruction; the fetch always completes.
REQ-018 Each end of instruction SHALL set instr_done=1 for exactly the following cycle, else 0.
REQ-019 At end of instruction with halt=1, next state SHALL be HALTED, with T=0 and running=0.
REQ-020 At end of instruction with halt=0, next state SHALL be RUN, with T=0.
REQ-021 halt asserted mid-instruction SHALL NOT alter T or instr before the boundary.
REQ-022 In HALTED, T SHALL stay 0 and instr SHALL hold.
REQ-023 In HALTED, when halt=0, the block SHALL return to RUN next cycle, with running=1 and T=0 (fetch begins).
REQ-024 stall SHALL have no effect in HALTED.
REQ-025 Priority SHALL be reset > stall > end-of-instruction/halt > increment.

Reset
REQ-026 On reset=1, next cycle SHALL have T=0, instr=16'h0000, state RUN, running=1, instr_done=0, and retired=0 (if present).
REQ-027 reset mid-instruction SHALL abort it, with no instr_done pulse and no count increment.
REQ-028 reset SHALL override stall and halt in the same cycle.

Configuration
REQ-029 Macro INSTR_COUNT_EN defined: retired SHALL be a 16-bit counter, +1 on each end of instruction, wrapping 16'hFFFF->16'h0000.
REQ-030 Macro INSTR_COUNT_EN undefined: port retired and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 Scenario: reset 1 cycle -> T=0, instr=0, running=1, instr_done=0.
REQ-032 Scenario: bus=16'h0300 during T=1, then uinstr=16'h45C0 at T=2, uinstr=0 at T=3.
REQ-032a Required response: instr=16'h0300 from T=2; T sequence 0,1,2,3,0; one instr_done pulse at the cycle T returns to 0.
REQ-033 Scenario: uinstr held nonzero, instr=16'h6400 -> T runs 0..7, then 0; instr_done pulses once after T=7.
REQ-034 Scenario: stall=1 for 3 cycles at T=2 -> T stays 2 for 3 cycles, instr unchanged, then resumes at 3.
REQ-035 Scenario: halt=1 raised at T=3, end at T=4 -> HALTED with running=0 and T=0 held.
REQ-035a Scenario: then halt=0 -> running=1 next cycle, T=0, then T=1.
REQ-036 Scenario (INSTR_COUNT_EN): 3 instructions -> retired=3; preload state near 16'hFFFF and retire 1 more -> 16'h0000.
